// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ram_arbiter_pkg: FSM state encodings, lane/port ids and address helper shared by the arbiter.
// Revision 1.0
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR       = 3'd3,
        ST_RMW_RD   = 3'd4,
        ST_RMW_WAIT = 3'd5,
        ST_RMW_WR   = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    localparam logic LANE_LO  = 1'b0;
    localparam logic LANE_HI  = 1'b1;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_VID = 1'b1;

    localparam int WAIT_W = 3;

    // Byte transactions address bytes; the SRAM is word-organised.
    function automatic logic [15:0] sram_word_addr(input logic [15:0] addr, input logic is_byte);
        return is_byte ? {1'b0, addr[15:1]} : addr;
    endfunction

    // States that hold the SRAM for 1+WAIT_STATES cycles.
    function automatic logic is_timed(input state_t s);
        return (s == ST_RD) || (s == ST_WR) || (s == ST_RMW_RD) || (s == ST_RMW_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_byte_lane.sv
`default_nettype none
// ram_byte_lane: byte extract (zero-extended) or byte merge into a 16-bit word, chosen by MERGE.
// Revision 1.0
module ram_byte_lane
    import ram_arbiter_pkg::*;
#(
    parameter bit MERGE = 1'b0
) (
    input  logic [15:0] word,
    input  logic        lane,
    input  logic [7:0]  byte_in,
    output logic [15:0] result
);

    logic [7:0]  picked;
    logic [15:0] merged;

    always_comb begin
        picked = (lane == LANE_HI) ? word[15:8] : word[7:0];
        merged = (lane == LANE_LO) ? {word[15:8], byte_in} : {byte_in, word[7:0]};
        result = MERGE ? merged : {8'h00, picked};
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: round-robin two-port arbiter and access sequencer in front of the SRAM interface,
// with read-modify-write for byte stores. Revision 1.0
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic        p0_byte,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic        p1_byte,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,

    output logic [15:0] ram_address,
    output logic [15:0] ram_dataIn,
    output logic        ram_write,
    input  logic [15:0] ram_dataOut
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_done;
    logic              entering_timed;

    logic              last_grant;
    logic              grant_port;
    logic              op_byte;
    logic              op_lane;
    logic [7:0]        op_wbyte;

    logic              any_req;
    logic              sel_port;
    logic              sel_we;
    logic              sel_byte;
    logic [15:0]       sel_addr;
    logic [15:0]       sel_wdata;

    logic [15:0]       lane_rd;
    logic [15:0]       lane_merged;
    logic [15:0]       rd_value;

    // Both requesting: the port not served last wins; otherwise whoever asks.
    always_comb begin
        any_req   = p0_req | p1_req;
        sel_port  = (p0_req & p1_req) ? ~last_grant : (p1_req ? PORT_VID : PORT_CPU);
        sel_we    = (sel_port == PORT_VID) ? p1_we    : p0_we;
        sel_byte  = (sel_port == PORT_VID) ? p1_byte  : p0_byte;
        sel_addr  = (sel_port == PORT_VID) ? p1_addr  : p0_addr;
        sel_wdata = (sel_port == PORT_VID) ? p1_wdata : p0_wdata;
    end

    ram_byte_lane #(.MERGE(1'b0)) u_extract (
        .word    (ram_dataOut),
        .lane    (op_lane),
        .byte_in (8'h00),
        .result  (lane_rd)
    );

    ram_byte_lane #(.MERGE(1'b1)) u_merge (
        .word    (ram_dataOut),
        .lane    (op_lane),
        .byte_in (op_wbyte),
        .result  (lane_merged)
    );

    assign rd_value = op_byte ? lane_rd : ram_dataOut;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wait_done  = (wait_cnt == '0);
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (sel_we && sel_byte) begin
                        next_state = ST_RMW_RD;
                    end else if (sel_we) begin
                        next_state = ST_WR;
                    end else begin
                        next_state = ST_RD;
                    end
                end
            end
            ST_RD:       if (wait_done) next_state = ST_RD_WAIT;
            ST_RD_WAIT:  next_state = ST_DONE;
            ST_WR:       if (wait_done) next_state = ST_DONE;
            ST_RMW_RD:   if (wait_done) next_state = ST_RMW_WAIT;
            ST_RMW_WAIT: next_state = ST_RMW_WR;
            ST_RMW_WR:   if (wait_done) next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        entering_timed = (next_state != state) && is_timed(next_state);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt    <= '0;
            last_grant  <= PORT_VID;
            grant_port  <= PORT_CPU;
            op_byte     <= 1'b0;
            op_lane     <= LANE_LO;
            op_wbyte    <= '0;
            ram_address <= '0;
            ram_dataIn  <= '0;
            ram_write   <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
        end else begin
            if (entering_timed) begin
                wait_cnt <= WAIT_LOAD;
            end else if (!wait_done) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end

            // Registered so the strobe covers exactly the write states.
            ram_write <= (next_state == ST_WR) || (next_state == ST_RMW_WR);
            p0_ack    <= (next_state == ST_DONE) && (grant_port == PORT_CPU);
            p1_ack    <= (next_state == ST_DONE) && (grant_port == PORT_VID);

            if (state == ST_IDLE && any_req) begin
                grant_port  <= sel_port;
                last_grant  <= sel_port;
                op_byte     <= sel_byte;
                op_lane     <= sel_addr[0];
                op_wbyte    <= sel_wdata[7:0];
                ram_address <= sram_word_addr(sel_addr, sel_byte);
                if (sel_we && !sel_byte) begin
                    ram_dataIn <= sel_wdata;
                end
            end

            if (state == ST_RMW_WAIT) begin
                ram_dataIn <= lane_merged;
            end

            if (state == ST_RD_WAIT) begin
                if (grant_port == PORT_CPU) begin
                    p0_rdata <= rd_value;
                end else begin
                    p1_rdata <= rd_value;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        p0_req, p0_we, p0_byte, p1_req, p1_we, p1_byte;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

    logic        a_p0_ack, a_p1_ack, a_ram_write;
    logic [15:0] a_p0_rdata, a_p1_rdata, a_ram_address, a_ram_dataIn, a_ram_dataOut;
    logic        b_p0_ack, b_p1_ack, b_ram_write;
    logic [15:0] b_p0_rdata, b_p1_rdata, b_ram_address, b_ram_dataIn, b_ram_dataOut;

    ram_arbiter #(.WAIT_STATES(0)) u_dut_a (
        .CLK(clk), .RST(rst),
        .p0_req(p0_req && !sel), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req && !sel), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
        .ram_address(a_ram_address), .ram_dataIn(a_ram_dataIn), .ram_write(a_ram_write),
        .ram_dataOut(a_ram_dataOut)
    );

    ram_arbiter #(.WAIT_STATES(2)) u_dut_b (
        .CLK(clk), .RST(rst),
        .p0_req(p0_req && sel), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req && sel), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .ram_address(b_ram_address), .ram_dataIn(b_ram_dataIn), .ram_write(b_ram_write),
        .ram_dataOut(b_ram_dataOut)
    );

    // SRAM models: registered read, write strobed in the low half of the clock
    logic [15:0] sram_a [0:65535];
    logic [15:0] sram_b [0:65535];
    always @(negedge clk) if (a_ram_write) sram_a[a_ram_address] <= a_ram_dataIn;
    always @(posedge clk) a_ram_dataOut <= sram_a[a_ram_address];
    always @(negedge clk) if (b_ram_write) sram_b[b_ram_address] <= b_ram_dataIn;
    always @(posedge clk) b_ram_dataOut <= sram_b[b_ram_address];

    logic        m_p0_ack, m_p1_ack, m_ram_write;
    logic [15:0] m_p0_rdata, m_p1_rdata, m_ram_address, m_ram_dataIn;
    assign m_p0_ack      = sel ? b_p0_ack      : a_p0_ack;
    assign m_p1_ack      = sel ? b_p1_ack      : a_p1_ack;
    assign m_ram_write   = sel ? b_ram_write   : a_ram_write;
    assign m_p0_rdata    = sel ? b_p0_rdata    : a_p0_rdata;
    assign m_p1_rdata    = sel ? b_p1_rdata    : a_p1_rdata;
    assign m_ram_address = sel ? b_ram_address : a_ram_address;
    assign m_ram_dataIn  = sel ? b_ram_dataIn  : a_ram_dataIn;

    // Reference model state: memory contents and last read result per instance/port
    logic [15:0] ref_mem [0:1][0:65535];
    logic [15:0] last_rd [0:1][0:1];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on instance inst (0: no wait states, 1: two wait states).
    // Called at a negedge while the DUT is idle; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input int inst, input int port, input logic we, input logic bt,
                           input logic [15:0] a, input logic [15:0] wd);
        int          ws;
        int          lane;
        int          exp_lat;
        int          k;
        int          bad_wr;
        int          other_ack;
        logic [15:0] wa;
        logic [15:0] old;
        logic [15:0] exp_word;
        logic [15:0] exp_rd;
        logic [15:0] addr1;
        logic [31:0] wmask;
        logic [31:0] exp_mask;
        logic        hit;
        ws        = (inst != 0) ? 2 : 0;
        wa        = bt ? (a >> 1) : a;
        lane      = bt ? int'(a[0]) : 0;
        old       = ref_mem[inst][wa];
        exp_rd    = bt ? ((old >> (8 * lane)) & 16'h00FF) : old;
        exp_word  = old;
        exp_mask  = '0;
        if (!we) begin
            exp_lat = 3 + ws;
        end else if (!bt) begin
            exp_lat  = 2 + ws;
            exp_word = wd;
        end else begin
            exp_lat  = 4 + 2 * ws;
            exp_word = (old & ~(16'h00FF << (8 * lane))) | ({8'h00, wd[7:0]} << (8 * lane));
        end
        for (int c = 1; c <= exp_lat; c++) begin
            if (we && !bt && c <= 1 + ws) exp_mask[c] = 1'b1;
            if (we && bt && c >= 3 + ws && c <= 3 + 2 * ws) exp_mask[c] = 1'b1;
        end

        sel = inst[0];
        if (port == 0) begin
            p0_we = we; p0_byte = bt; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_byte = bt; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
        end

        k = 0; bad_wr = 0; other_ack = 0; wmask = '0; addr1 = 16'hxxxx; hit = 1'b0;
        while (k < 40 && !hit) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (k == 1) addr1 = m_ram_address;
            if (m_ram_write) begin
                if (k < 32) wmask[k] = 1'b1;
                if (m_ram_address !== wa || m_ram_dataIn !== exp_word) bad_wr++;
            end
            if ((port == 0) ? m_p1_ack : m_p0_ack) other_ack++;
            hit = (port == 0) ? m_p0_ack : m_p1_ack;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;

        check($sformatf("ack_latency i%0d p%0d we%0d b%0d", inst, port, we, bt), k, exp_lat);
        check("sram_address", {16'h0, addr1}, {16'h0, wa});
        check("write_strobe_cycles", wmask, exp_mask);
        check("write_addr_data_stable", bad_wr, 0);
        check("other_port_ack", other_ack, 0);
        if (!we) begin
            check("read_data", (port == 0) ? m_p0_rdata : m_p1_rdata, exp_rd);
            last_rd[inst][port] = exp_rd;
        end
        check("other_port_rdata_held", (port == 0) ? m_p1_rdata : m_p0_rdata, last_rd[inst][1 - port]);
        if (we) ref_mem[inst][wa] = exp_word;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ord [$];
        int          n0, n1, both;
        int          rp;
        logic        rwe, rbt, rlane;
        logic [15:0] rwa;

        for (int i = 0; i < 65536; i++) begin
            ref_mem[0][i] = '0;
            ref_mem[1][i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            last_rd[i][0] = '0;
            last_rd[i][1] = '0;
        end
        rst = 1'b1; sel = 1'b0;
        p0_req = 0; p0_we = 0; p0_byte = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_byte = 0; p1_addr = '0; p1_wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_a_ram_write", a_ram_write, 0);
        check("rst_a_ram_address", a_ram_address, 0);
        check("rst_a_ram_dataIn", a_ram_dataIn, 0);
        check("rst_a_acks", {a_p0_ack, a_p1_ack}, 0);
        check("rst_a_rdata", {a_p0_rdata, a_p1_rdata}, 0);
        check("rst_b_ram_write", b_ram_write, 0);
        check("rst_b_ram_address", b_ram_address, 0);
        check("rst_b_ram_dataIn", b_ram_dataIn, 0);
        check("rst_b_acks", {b_p0_ack, b_p1_ack}, 0);
        check("rst_b_rdata", {b_p0_rdata, b_p1_rdata}, 0);

        // Contention straight after reset: both held continuously, grants must alternate from port 0
        rst = 1'b0;
        p0_we = 1; p0_byte = 0; p0_addr = 16'h0100; p0_wdata = 16'h5000;
        p1_we = 1; p1_byte = 0; p1_addr = 16'h0200; p1_wdata = 16'h6000;
        p0_req = 1; p1_req = 1;
        n0 = 0; n1 = 0; both = 0;
        for (int cyc = 0; cyc < 100 && ord.size() < 6; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_p0_ack && a_p1_ack) both++;
            if (a_p0_ack) begin
                ord.push_back(0);
                ref_mem[0][p0_addr] = p0_wdata;
                n0++;
                p0_addr = 16'h0100 + 16'(n0); p0_wdata = 16'h5000 + 16'(n0);
            end
            if (a_p1_ack) begin
                ord.push_back(1);
                ref_mem[0][p1_addr] = p1_wdata;
                n1++;
                p1_addr = 16'h0200 + 16'(n1); p1_wdata = 16'h6000 + 16'(n1);
            end
        end
        p0_req = 0; p1_req = 0;
        @(negedge clk);
        check("contention_both_acked", both, 0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("contention_grant_%0d", i), (ord.size() > i) ? ord[i] : -1, i % 2);
        end
        run_txn(0, 1, 0, 0, 16'h0101, 16'h0);
        run_txn(0, 0, 0, 0, 16'h0201, 16'h0);

        // Word write then read back
        run_txn(0, 0, 1, 0, 16'h0040, 16'h1234);
        run_txn(0, 0, 0, 0, 16'h0040, 16'h0);
        check("tp_word_readback", m_p0_rdata, 16'h1234);

        // Byte read-modify-write on the high lane
        run_txn(0, 1, 1, 0, 16'h0010, 16'hAABB);
        run_txn(0, 1, 1, 1, 16'h0021, 16'h00CC);
        run_txn(0, 1, 0, 0, 16'h0010, 16'h0);
        check("tp_rmw_word", m_p1_rdata, 16'hCCBB);
        run_txn(0, 0, 0, 1, 16'h0020, 16'h0);
        check("tp_byte_read", m_p0_rdata, 16'h00BB);

        // Random traffic on a small window so bytes and words alias
        for (int i = 0; i < 16; i++) run_txn(0, i % 2, 1, 0, 16'h0040 + 16'(i), 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            rp    = int'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            rbt   = 1'($urandom_range(0, 1));
            rlane = 1'($urandom_range(0, 1));
            rwa   = 16'h0040 + 16'($urandom_range(0, 15));
            run_txn(0, rp, rwe, rbt, rbt ? {rwa[14:0], rlane} : rwa, 16'($urandom));
        end

        // Two wait states
        for (int i = 0; i < 16; i++) run_txn(1, i % 2, 1, 0, 16'h0040 + 16'(i), 16'($urandom));
        run_txn(1, 0, 0, 0, 16'h0041, 16'h0);
        run_txn(1, 1, 1, 1, 16'h0083, 16'h00CC);
        run_txn(1, 1, 0, 0, 16'h0041, 16'h0);
        for (int i = 0; i < 20; i++) begin
            rp    = int'($urandom_range(0, 1));
            rwe   = 1'($urandom_range(0, 1));
            rbt   = 1'($urandom_range(0, 1));
            rlane = 1'($urandom_range(0, 1));
            rwa   = 16'h0040 + 16'($urandom_range(0, 15));
            run_txn(1, rp, rwe, rbt, rbt ? {rwa[14:0], rlane} : rwa, 16'($urandom));
        end

        // Reset in the middle of a word write: strobe must drop at once and the write is lost
        sel = 1'b0;
        p0_we = 1; p0_byte = 0; p0_addr = 16'h0045; p0_wdata = ~ref_mem[0][16'h0045];
        p0_req = 1;
        @(posedge clk);
        #1;
        check("rstmid_write_started", a_ram_write, 1);
        rst = 1'b1;
        #1;
        check("rstmid_write_async_drop", a_ram_write, 0);
        check("rstmid_no_ack", {a_p0_ack, a_p1_ack}, 0);
        p0_req = 0;
        @(negedge clk);
        check("rstmid_write_held_low", a_ram_write, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_rd[i][0] = '0;
            last_rd[i][1] = '0;
        end
        @(negedge clk);
        check("rstmid_no_ack_after", {a_p0_ack, a_p1_ack}, 0);
        check("rstmid_rdata_cleared", {a_p0_rdata, a_p1_rdata}, 0);
        run_txn(0, 0, 0, 0, 16'h0045, 16'h0);
        run_txn(0, 1, 1, 1, 16'h008A, 16'h0077);
        run_txn(0, 0, 0, 0, 16'h0045, 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
